// File: rtl/rx_sync_monitor_pkg.sv
// Shared encodings for the receive symbol-lock monitor.
// State codes are visible on the state output, so they are fixed here.
package rx_sync_monitor_pkg;

   typedef enum logic [1:0] {
      LOS   = 2'd0,
      ACQ   = 2'd1,
      SYNC  = 2'd2,
      CHECK = 2'd3
   } sync_state_e;

   localparam logic [7:0] K28_5 = 8'hBC;

   function automatic logic is_comma(
      input logic [7:0] d,
      input logic       k,
      input logic       inv
   );
      return !inv && k && (d == K28_5);
   endfunction

endpackage

// File: rtl/rx_sync_monitor_err_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment leaves the count at one.
module err_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = inc ? W'(1) : '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/rx_sync_monitor.sv
// Symbol-lock FSM over decoded 8b/10b symbols; strips commas and
// forwards in-sync valid symbols with one registered cycle of latency.
module rx_sync_monitor
   import rx_sync_monitor_pkg::*;
#(
   parameter int ACQ_COMMAS = 3,
   parameter int ERR_LIMIT  = 4,
   parameter int GOOD_RUN   = 4,
   parameter int ERRCNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enb,
   input  logic                symValid,
   input  logic [7:0]          dataIn,
   input  logic                kIn,
   input  logic                invalidIn,
   input  logic                errClr,
   output logic                syncOk,
   output logic [1:0]          state,
   output logic                syncLost,
   output logic [7:0]          dataOut,
   output logic                kOut,
   output logic                dataValid,
   output logic [ERRCNT_W-1:0] errTotal
);

   localparam int CW = $clog2(ACQ_COMMAS) + 1;
   localparam int EW = $clog2(ERR_LIMIT) + 1;
   localparam int GW = $clog2(GOOD_RUN) + 1;

   localparam logic [CW-1:0] ACQ_LAST  = CW'(ACQ_COMMAS - 1);
   localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_RUN - 1);

   sync_state_e   state_d, state_q;
   logic [CW-1:0] comma_cnt_d, comma_cnt_q;
   logic [EW-1:0] err_cnt_d, err_cnt_q;
   logic [GW-1:0] good_cnt_d, good_cnt_q;
   logic          sync_lost_d, sync_lost_q;
   logic          data_valid_d, data_valid_q;
   logic [7:0]    data_out_d, data_out_q;
   logic          k_out_d, k_out_q;

   logic accept;
   logic bad;
   logic comma;
   logic in_sync;

   assign accept  = enb && symValid;
   assign bad     = invalidIn;
   assign comma   = is_comma(dataIn, kIn, invalidIn);
   assign in_sync = (state_q == SYNC) || (state_q == CHECK);

   always_comb begin
      state_d      = state_q;
      comma_cnt_d  = comma_cnt_q;
      err_cnt_d    = err_cnt_q;
      good_cnt_d   = good_cnt_q;
      sync_lost_d  = 1'b0;
      data_valid_d = 1'b0;
      data_out_d   = data_out_q;
      k_out_d      = k_out_q;

      if (accept) begin
         if (in_sync && !bad && !comma) begin
            data_valid_d = 1'b1;
            data_out_d   = dataIn;
            k_out_d      = kIn;
         end

         unique case (state_q)
            LOS, ACQ: begin
               // comma_cnt_q is 0 in LOS, so one path covers ACQ_COMMAS=1
               if (bad) begin
                  state_d     = LOS;
                  comma_cnt_d = '0;
               end else if (comma) begin
                  if (comma_cnt_q == ACQ_LAST) begin
                     state_d     = SYNC;
                     comma_cnt_d = '0;
                  end else begin
                     state_d     = ACQ;
                     comma_cnt_d = comma_cnt_q + CW'(1);
                  end
               end
            end
            SYNC: begin
               if (bad) begin
                  state_d    = CHECK;
                  err_cnt_d  = EW'(1);
                  good_cnt_d = '0;
               end
            end
            CHECK: begin
               if (bad) begin
                  good_cnt_d = '0;
                  if (err_cnt_q == ERR_LAST) begin
                     state_d     = LOS;
                     sync_lost_d = 1'b1;
                     err_cnt_d   = '0;
                     comma_cnt_d = '0;
                  end else begin
                     err_cnt_d = err_cnt_q + EW'(1);
                  end
               end else if (good_cnt_q == GOOD_LAST) begin
                  good_cnt_d = '0;
                  err_cnt_d  = err_cnt_q - EW'(1);
                  if (err_cnt_q == EW'(1)) begin
                     state_d = SYNC;
                  end
               end else begin
                  good_cnt_d = good_cnt_q + GW'(1);
               end
            end
            default: state_d = LOS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= LOS;
         comma_cnt_q  <= '0;
         err_cnt_q    <= '0;
         good_cnt_q   <= '0;
         sync_lost_q  <= 1'b0;
         data_valid_q <= 1'b0;
         data_out_q   <= '0;
         k_out_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         comma_cnt_q  <= comma_cnt_d;
         err_cnt_q    <= err_cnt_d;
         good_cnt_q   <= good_cnt_d;
         sync_lost_q  <= sync_lost_d;
         data_valid_q <= data_valid_d;
         data_out_q   <= data_out_d;
         k_out_q      <= k_out_d;
      end
   end

   err_sat_counter #(
      .W(ERRCNT_W)
   ) u_err_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (enb && errClr),
      .inc  (accept && bad),
      .count(errTotal)
   );

   assign state     = state_q;
   assign syncOk    = (state_q == SYNC) || (state_q == CHECK);
   assign syncLost  = sync_lost_q;
   assign dataValid = data_valid_q;
   assign dataOut   = data_out_q;
   assign kOut      = k_out_q;

endmodule

// File: tb/tb_rx_sync_monitor.sv
// Scoreboard bench: stimulus queues expected per-cycle status and
// forwarded symbols; a monitor pops and compares after each edge.
module tb_rx_sync_monitor;

   logic       clk = 1'b0;
   logic       rst, enb, symValid, kIn, invalidIn, errClr;
   logic [7:0] dataIn;

   logic       syncOk, syncLost, kOut, dataValid;
   logic [1:0] state;
   logic [7:0] dataOut, errTotal;

   logic       w2_syncOk, w2_syncLost, w2_kOut, w2_dataValid;
   logic [1:0] w2_state, w2_errTotal;
   logic [7:0] w2_dataOut;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0] st;
      logic       lost;
      logic       dv;
      logic [7:0] e1;
      logic [1:0] e2;
      logic       rchk;
   } exp_t;

   exp_t       cyc_q[$];
   logic [8:0] dat_q[$];

   always #5 clk = ~clk;

   rx_sync_monitor dut (
      .clk(clk), .rst(rst), .enb(enb), .symValid(symValid),
      .dataIn(dataIn), .kIn(kIn), .invalidIn(invalidIn),
      .errClr(errClr), .syncOk(syncOk), .state(state),
      .syncLost(syncLost), .dataOut(dataOut), .kOut(kOut),
      .dataValid(dataValid), .errTotal(errTotal)
   );

   rx_sync_monitor #(.ERRCNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .enb(enb), .symValid(symValid),
      .dataIn(dataIn), .kIn(kIn), .invalidIn(invalidIn),
      .errClr(errClr), .syncOk(w2_syncOk), .state(w2_state),
      .syncLost(w2_syncLost), .dataOut(w2_dataOut), .kOut(w2_kOut),
      .dataValid(w2_dataValid), .errTotal(w2_errTotal)
   );

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t       x;
      logic [8:0] d;
      #1;
      if (cyc_q.size() > 0) begin
         x = cyc_q.pop_front();
         chk("state", int'(state), int'(x.st));
         chk("syncOk", int'(syncOk), int'(x.st[1]));
         chk("syncLost", int'(syncLost), int'(x.lost));
         chk("dataValid", int'(dataValid), int'(x.dv));
         chk("errTotal", int'(errTotal), int'(x.e1));
         chk("errTotal_w2", int'(w2_errTotal), int'(x.e2));
         if (x.rchk) begin
            chk("rst_dataOut", int'(dataOut), 0);
            chk("rst_kOut", int'(kOut), 0);
         end
      end
      if (dataValid) begin
         if (dat_q.size() == 0) begin
            chk("unexpected_data", int'({kOut, dataOut}), 0);
         end else begin
            d = dat_q.pop_front();
            chk("dataOut", int'(dataOut), int'(d[7:0]));
            chk("kOut", int'(kOut), int'(d[8]));
         end
      end
   end

   task automatic drive(
      input logic       r, en, sv,
      input logic [7:0] d,
      input logic       k, inv, clr,
      input logic [1:0] st,
      input logic       lost, dv,
      input logic [7:0] e1,
      input logic [1:0] e2
   );
      exp_t x;
      rst = r; enb = en; symValid = sv;
      dataIn = d; kIn = k; invalidIn = inv; errClr = clr;
      x.st = st; x.lost = lost; x.dv = dv;
      x.e1 = e1; x.e2 = e2; x.rchk = r;
      cyc_q.push_back(x);
      if (dv) dat_q.push_back({k, d});
      @(posedge clk);
      #2;
   endtask

   task automatic sym(
      input logic [7:0] d,
      input logic       k, inv,
      input logic [1:0] st,
      input logic       lost, dv,
      input logic [7:0] e1,
      input logic [1:0] e2
   );
      drive(0, 1, 1, d, k, inv, 0, st, lost, dv, e1, e2);
   endtask

   initial begin
      // reset and acquire
      drive(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      sym(8'hBC, 1, 0, 1, 0, 0, 0, 0);
      sym(8'hBC, 1, 0, 1, 0, 0, 0, 0);
      sym(8'hBC, 1, 0, 2, 0, 0, 0, 0);
      // forwarding, comma stripped, K28.0 kept
      sym(8'h11, 0, 0, 2, 0, 1, 0, 0);
      sym(8'h22, 0, 0, 2, 0, 1, 0, 0);
      sym(8'hBC, 1, 0, 2, 0, 0, 0, 0);
      sym(8'h1C, 1, 0, 2, 0, 1, 0, 0);
      // isolated error then recovery
      sym(8'h00, 0, 1, 3, 0, 0, 1, 1);
      sym(8'h33, 0, 0, 3, 0, 1, 1, 1);
      sym(8'h44, 0, 0, 3, 0, 1, 1, 1);
      sym(8'h55, 0, 0, 3, 0, 1, 1, 1);
      sym(8'h66, 0, 0, 2, 0, 1, 1, 1);
      // clustered errors force loss of sync
      sym(8'h00, 0, 1, 3, 0, 0, 2, 2);
      sym(8'h77, 0, 0, 3, 0, 1, 2, 2);
      sym(8'h00, 0, 1, 3, 0, 0, 3, 3);
      sym(8'h00, 0, 1, 3, 0, 0, 4, 3);
      sym(8'h00, 0, 1, 0, 1, 0, 5, 3);
      sym(8'h88, 0, 0, 0, 0, 0, 5, 3);
      // gating
      drive(0, 0, 1, 8'hBC, 1, 0, 0, 0, 0, 0, 5, 3);
      drive(0, 1, 0, 8'hBC, 1, 0, 0, 0, 0, 0, 5, 3);
      // ACQ abort
      sym(8'hBC, 1, 0, 1, 0, 0, 5, 3);
      sym(8'hBC, 1, 0, 1, 0, 0, 5, 3);
      sym(8'h00, 0, 1, 0, 0, 0, 6, 3);
      sym(8'hBC, 1, 0, 1, 0, 0, 6, 3);
      drive(0, 0, 1, 8'hBC, 1, 0, 0, 1, 0, 0, 6, 3);
      sym(8'hBC, 1, 0, 1, 0, 0, 6, 3);
      sym(8'hBC, 1, 0, 2, 0, 0, 6, 3);
      sym(8'h99, 0, 0, 2, 0, 1, 6, 3);
      // clear coinciding with a bad symbol
      drive(0, 1, 1, 8'h00, 0, 1, 1, 3, 0, 0, 1, 1);
      sym(8'hAA, 0, 0, 3, 0, 1, 1, 1);
      // reset mid-CHECK
      drive(1, 1, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
      sym(8'hBC, 1, 0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #3;
      chk("queues_empty", cyc_q.size() + dat_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
